control_unit_fsm: RTL and testbench
===================================

CONTROL_UNIT_FSM -- requirements
Module: control_unit_fsm

Interface
REQ-001 Clock  in  1  rising-edge clock for all state.
REQ-002 Reset  in  1  synchronous, active-high reset; sampled on Clock.
REQ-003 Start  in  1  one-cycle start request; honoured only in IDLE.
REQ-004 Instr  in  16  IR contents: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [2:0] ignored.
REQ-005 Zero  in  1  datapath flag, high when ALU_Out register == 0.
REQ-006 Memory_Reset  out  1  memory program-load strobe.
REQ-007 Mem_Read  out  1  memory read strobe; datapath MDR captures Read_Data.
REQ-008 Mem_Write  out  1  memory write strobe; write data = B latch.
REQ-009 Mem_Addr_Src  out  1  memory address select: 0 = PC, 1 = A latch.
REQ-010 IR_Write  out  1  IR load enable.
REQ-011 PC_Write  out  1  PC load enable.
REQ-012 PC_Src  out  1  PC source: 0 = PC+1, 1 = register-file Read_Data.
REQ-013 Reg_Number  out  3  register-file index.
REQ-014 RegFile_Read  out  1  register-file read enable.
REQ-015 RegFileWrite  out  1  register-file write enable.
REQ-016 WB_Src  out  1  write-back source: 0 = ALU_Out, 1 = MDR.
REQ-017 A_Write  out  1  A latch load enable.
REQ-018 B_Write  out  1  B latch load enable.
REQ-019 ALU_Control_Signal  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 not.
REQ-020 ALU_Out_Write  out  1  ALU_Out register load enable.
REQ-021 Halted  out  1  high while in HALT.
REQ-022 Illegal_Op  out  1  one-cycle pulse on an undefined opcode.
REQ-023 Instr_Count  out  16  retired-instruction counter.

Function
REQ-024 State register, 4-bit encoding: INIT=0, IDLE=1, FETCH=2, FETCH_IR=3, DECODE=4, READ_B=5, EXEC=6, WB_ALU=7, MEM_RD=8, WB_MEM=9, MEM_WR=10, BR_CHK=11, HALT=12; all other codes go to INIT on the next edge.
REQ-025 Outputs: combinational from state and Instr; every strobe not listed for a state is 0; ALU_Control_Signal = 000 when not listed.
REQ-026 INIT: Memory_Reset=1 -> IDLE. IDLE: all strobes 0; Start=1 -> FETCH, else stay.
REQ-027 FETCH: Mem_Addr_Src=0, Mem_Read=1 -> FETCH_IR. FETCH_IR: IR_Write=1, PC_Write=1, PC_Src=0 -> DECODE.
REQ-028 DECODE: Reg_Number=rs1, RegFile_Read=1, A_Write=1. Next state by opcode:
- 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0110 ST, 0111 BEQ -> READ_B
- 0100 NOT -> EXEC
- 0101 LD -> MEM_RD
- 1111 HALT -> HALT
- any other opcode -> FETCH with Illegal_Op=1
REQ-029 READ_B: Reg_Number=rs2, RegFile_Read=1, B_Write=1; ST -> MEM_WR, otherwise -> EXEC.
REQ-030 EXEC: ALU_Out_Write=1; ALU_Control_Signal = ADD 000, SUB 001, AND 010, OR 011, NOT 100, BEQ 001; BEQ -> BR_CHK, otherwise -> WB_ALU.
REQ-031 WB_ALU: Reg_Number=rd, RegFileWrite=1, WB_Src=0 -> FETCH.
REQ-032 MEM_RD: Mem_Addr_Src=1, Mem_Read=1 -> WB_MEM. WB_MEM: Reg_Number=rd, RegFileWrite=1, WB_Src=1 -> FETCH.
REQ-033 MEM_WR: Mem_Addr_Src=1, Mem_Write=1 -> FETCH.
REQ-034 BR_CHK: Reg_Number=rd, RegFile_Read=1; if Zero=1 then PC_Src=1 and PC_Write=1 -> FETCH.
REQ-035 HALT: Halted=1; sticky, Start ignored; exit only via Reset.
REQ-036 Latency from FETCH to next FETCH: R-type and BEQ 6 cycles; NOT, LD, ST 5 cycles; illegal opcode 3 cycles.
REQ-037 Instr_Count increments by 1 on the last cycle of each retired instruction (WB_ALU, WB_MEM, MEM_WR, BR_CHK); it wraps 0xFFFF -> 0x0000; illegal opcodes and HALT are not counted.

Reset
REQ-038 While Reset=1, all strobe outputs are forced to 0, Halted and Illegal_Op are 0, and Instr_Count loads 0; the next state is INIT, including when Reset arrives mid-instruction or in HALT.

Structure
REQ-039 Shared package cpu_ctrl_pkg holds the opcode constants, ALU control codes and state encodings; the datapath ALU uses the same ALU codes.
REQ-040 Opcode-to-ALU-code and opcode-class decoding live in one combinational sub-module, ctrl_decode.

Verification
REQ-041 Reset, then Start; Instr=0x0628 (ADD r3,r0,r5) -> Memory_Reset in INIT; 6 cycles from FETCH to FETCH; WB_ALU with Reg_Number=3, RegFileWrite=1; Instr_Count=1.
REQ-042 Instr=0x5440 (LD r2,[r1]) -> MEM_RD with Mem_Addr_Src=1, Mem_Read=1; WB_MEM with WB_Src=1, Reg_Number=2; 5 cycles.
REQ-043 BEQ with Zero=1 -> BR_CHK with PC_Src=1, PC_Write=1; repeat with Zero=0 -> PC_Write=0; both runs increment Instr_Count.
REQ-044 Instr=0x8000 -> Illegal_Op pulses in DECODE, return to FETCH, Instr_Count unchanged; Instr=0xF000 -> Halted stays 1 for 20 cycles while Start pulses are ignored.
REQ-045 Reset asserted in EXEC -> all strobes 0 in that cycle, INIT next, Instr_Count=0; Instr_Count preset near 0xFFFF -> wraps to 0x0000.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU control path.
// Holds the opcode constants, the ALU operation codes (also used by the
// datapath ALU), the controller state encoding and the opcode classes
// produced by ctrl_decode.
package cpu_ctrl_pkg;

  // Opcodes, Instr[15:12]
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_NOT  = 4'h4;
  localparam logic [3:0] OP_LD   = 4'h5;
  localparam logic [3:0] OP_ST   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  // ALU operation codes shared with the datapath ALU
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_NOT = 3'b100
  } alu_op_e;

  // Controller state encoding (codes 13..15 are unused)
  typedef enum logic [3:0] {
    S_INIT     = 4'd0,
    S_IDLE     = 4'd1,
    S_FETCH    = 4'd2,
    S_FETCH_IR = 4'd3,
    S_DECODE   = 4'd4,
    S_READ_B   = 4'd5,
    S_EXEC     = 4'd6,
    S_WB_ALU   = 4'd7,
    S_MEM_RD   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BR_CHK   = 4'd11,
    S_HALT     = 4'd12
  } state_e;

  // Instruction classes that steer the sequencing after DECODE
  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,  // ADD/SUB/AND/OR: two source reads, ALU, write-back
    CLS_NOT     = 3'd1,  // single source, ALU, write-back
    CLS_LD      = 3'd2,
    CLS_ST      = 3'd3,
    CLS_BEQ     = 3'd4,
    CLS_HALT    = 3'd5,
    CLS_ILLEGAL = 3'd6
  } op_class_e;

  // Field extraction helpers for the 16-bit instruction word
  function automatic logic [2:0] instr_rd(input logic [15:0] instr);
    return instr[11:9];
  endfunction

  function automatic logic [2:0] instr_rs1(input logic [15:0] instr);
    return instr[8:6];
  endfunction

  function automatic logic [2:0] instr_rs2(input logic [15:0] instr);
    return instr[5:3];
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder.
// Ports:
//   opcode   in  4  Instr[15:12]
//   op_class out    instruction class used by the sequencer
//   alu_ctrl out    ALU operation for the EXEC step (ADD when not applicable)
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output op_class_e  op_class,
  output alu_op_e    alu_ctrl
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    alu_ctrl = ALU_ADD;
    case (opcode)
      OP_ADD:  begin op_class = CLS_ALU;  alu_ctrl = ALU_ADD; end
      OP_SUB:  begin op_class = CLS_ALU;  alu_ctrl = ALU_SUB; end
      OP_AND:  begin op_class = CLS_ALU;  alu_ctrl = ALU_AND; end
      OP_OR:   begin op_class = CLS_ALU;  alu_ctrl = ALU_OR;  end
      OP_NOT:  begin op_class = CLS_NOT;  alu_ctrl = ALU_NOT; end
      OP_LD:   op_class = CLS_LD;
      OP_ST:   op_class = CLS_ST;
      // Branch compares by subtraction; Zero comes back from ALU_Out
      OP_BEQ:  begin op_class = CLS_BEQ;  alu_ctrl = ALU_SUB; end
      OP_HALT: op_class = CLS_HALT;
      default: op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_unit_fsm.sv
// Multi-cycle CPU control unit.
// Sequences fetch / decode / execute / memory / write-back for a 16-bit ISA
// and counts retired instructions.
// Ports:
//   Clock, Reset (sync, active-high)
//   Start              one-cycle start request, honoured in IDLE only
//   Instr[15:0]        IR contents: opcode, rd, rs1, rs2
//   Zero               datapath flag, ALU_Out == 0
//   Memory_Reset .. ALU_Out_Write   datapath strobes/selects (Moore on state,
//                                   field selects taken from Instr)
//   Halted             high while halted
//   Illegal_Op         one-cycle pulse in DECODE on an undefined opcode
//   Instr_Count[15:0]  retired-instruction counter, wraps
module control_unit_fsm
  import cpu_ctrl_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] Instr,
  input  logic        Zero,
  output logic        Memory_Reset,
  output logic        Mem_Read,
  output logic        Mem_Write,
  output logic        Mem_Addr_Src,
  output logic        IR_Write,
  output logic        PC_Write,
  output logic        PC_Src,
  output logic [2:0]  Reg_Number,
  output logic        RegFile_Read,
  output logic        RegFileWrite,
  output logic        WB_Src,
  output logic        A_Write,
  output logic        B_Write,
  output logic [2:0]  ALU_Control_Signal,
  output logic        ALU_Out_Write,
  output logic        Halted,
  output logic        Illegal_Op,
  output logic [15:0] Instr_Count
);

  state_e     state_q;
  state_e     state_d;
  op_class_e  op_class;
  alu_op_e    alu_ctrl;
  logic       retire;
  logic [15:0] instr_count_q;
  logic       unused_instr_bits;

  assign unused_instr_bits = ^Instr[2:0];

  ctrl_decode u_decode (
    .opcode   (Instr[15:12]),
    .op_class (op_class),
    .alu_ctrl (alu_ctrl)
  );

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  always_ff @(posedge Clock) begin
    if (Reset)       instr_count_q <= '0;
    else if (retire) instr_count_q <= instr_count_q + 16'd1;
  end

  assign Instr_Count = instr_count_q;

  always_comb begin
    state_d            = S_INIT;
    retire             = 1'b0;
    Memory_Reset       = 1'b0;
    Mem_Read           = 1'b0;
    Mem_Write          = 1'b0;
    Mem_Addr_Src       = 1'b0;
    IR_Write           = 1'b0;
    PC_Write           = 1'b0;
    PC_Src             = 1'b0;
    Reg_Number         = '0;
    RegFile_Read       = 1'b0;
    RegFileWrite       = 1'b0;
    WB_Src             = 1'b0;
    A_Write            = 1'b0;
    B_Write            = 1'b0;
    ALU_Control_Signal = ALU_ADD;
    ALU_Out_Write      = 1'b0;
    Halted             = 1'b0;
    Illegal_Op         = 1'b0;

    case (state_q)
      S_INIT: begin
        Memory_Reset = 1'b1;
        state_d      = S_IDLE;
      end
      S_IDLE: begin
        state_d = Start ? S_FETCH : S_IDLE;
      end
      S_FETCH: begin
        Mem_Addr_Src = 1'b0;
        Mem_Read     = 1'b1;
        state_d      = S_FETCH_IR;
      end
      S_FETCH_IR: begin
        IR_Write = 1'b1;
        PC_Write = 1'b1;
        PC_Src   = 1'b0;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        Reg_Number   = instr_rs1(Instr);
        RegFile_Read = 1'b1;
        A_Write      = 1'b1;
        case (op_class)
          CLS_ALU, CLS_ST, CLS_BEQ: state_d = S_READ_B;
          CLS_NOT:                  state_d = S_EXEC;
          CLS_LD:                   state_d = S_MEM_RD;
          CLS_HALT:                 state_d = S_HALT;
          default: begin
            Illegal_Op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_READ_B: begin
        Reg_Number   = instr_rs2(Instr);
        RegFile_Read = 1'b1;
        B_Write      = 1'b1;
        state_d      = (op_class == CLS_ST) ? S_MEM_WR : S_EXEC;
      end
      S_EXEC: begin
        ALU_Out_Write      = 1'b1;
        ALU_Control_Signal = alu_ctrl;
        state_d            = (op_class == CLS_BEQ) ? S_BR_CHK : S_WB_ALU;
      end
      S_WB_ALU: begin
        Reg_Number   = instr_rd(Instr);
        RegFileWrite = 1'b1;
        WB_Src       = 1'b0;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_RD: begin
        Mem_Addr_Src = 1'b1;
        Mem_Read     = 1'b1;
        state_d      = S_WB_MEM;
      end
      S_WB_MEM: begin
        Reg_Number   = instr_rd(Instr);
        RegFileWrite = 1'b1;
        WB_Src       = 1'b1;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WR: begin
        Mem_Addr_Src = 1'b1;
        Mem_Write    = 1'b1;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_BR_CHK: begin
        // rd supplies the branch target through the register-file read port
        Reg_Number   = instr_rd(Instr);
        RegFile_Read = 1'b1;
        PC_Src       = Zero;
        PC_Write     = Zero;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_HALT: begin
        Halted  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_INIT;
    endcase

    // Reset masks every output combinationally, so a reset landing
    // mid-instruction produces no strobes in that same cycle.
    if (Reset) begin
      retire             = 1'b0;
      Memory_Reset       = 1'b0;
      Mem_Read           = 1'b0;
      Mem_Write          = 1'b0;
      Mem_Addr_Src       = 1'b0;
      IR_Write           = 1'b0;
      PC_Write           = 1'b0;
      PC_Src             = 1'b0;
      Reg_Number         = '0;
      RegFile_Read       = 1'b0;
      RegFileWrite       = 1'b0;
      WB_Src             = 1'b0;
      A_Write            = 1'b0;
      B_Write            = 1'b0;
      ALU_Control_Signal = ALU_ADD;
      ALU_Out_Write      = 1'b0;
      Halted             = 1'b0;
      Illegal_Op         = 1'b0;
      state_d            = S_INIT;
    end
  end

endmodule

// File: tb/tb_control_unit_fsm.sv
// Self-checking bench for control_unit_fsm. Each instruction is expanded
// into the list of per-cycle control bundles implied by its micro-operation
// sequence, and the DUT outputs are compared against that list every cycle.
module tb_control_unit_fsm;

  typedef struct packed {
    logic       mem_reset;
    logic       mem_read;
    logic       mem_write;
    logic       addr_src;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic [2:0] reg_num;
    logic       rf_read;
    logic       rf_write;
    logic       wb_src;
    logic       a_write;
    logic       b_write;
    logic [2:0] alu;
    logic       alu_out_write;
    logic       halted;
    logic       illegal;
  } ctl_t;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [15:0] Instr = '0;
  logic        Zero  = 1'b0;
  logic        Memory_Reset, Mem_Read, Mem_Write, Mem_Addr_Src, IR_Write;
  logic        PC_Write, PC_Src, RegFile_Read, RegFileWrite, WB_Src;
  logic        A_Write, B_Write, ALU_Out_Write, Halted, Illegal_Op;
  logic [2:0]  Reg_Number, ALU_Control_Signal;
  logic [15:0] Instr_Count;

  control_unit_fsm dut (
    .Clock              (Clock),
    .Reset              (Reset),
    .Start              (Start),
    .Instr              (Instr),
    .Zero               (Zero),
    .Memory_Reset       (Memory_Reset),
    .Mem_Read           (Mem_Read),
    .Mem_Write          (Mem_Write),
    .Mem_Addr_Src       (Mem_Addr_Src),
    .IR_Write           (IR_Write),
    .PC_Write           (PC_Write),
    .PC_Src             (PC_Src),
    .Reg_Number         (Reg_Number),
    .RegFile_Read       (RegFile_Read),
    .RegFileWrite       (RegFileWrite),
    .WB_Src             (WB_Src),
    .A_Write            (A_Write),
    .B_Write            (B_Write),
    .ALU_Control_Signal (ALU_Control_Signal),
    .ALU_Out_Write      (ALU_Out_Write),
    .Halted             (Halted),
    .Illegal_Op         (Illegal_Op),
    .Instr_Count        (Instr_Count)
  );

  always #5 Clock = ~Clock;

  ctl_t got;
  assign got = {Memory_Reset, Mem_Read, Mem_Write, Mem_Addr_Src, IR_Write,
                PC_Write, PC_Src, Reg_Number, RegFile_Read, RegFileWrite,
                WB_Src, A_Write, B_Write, ALU_Control_Signal, ALU_Out_Write,
                Halted, Illegal_Op};

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [15:0] mcount   = '0;
  ctl_t        exp_q[$];

  // Called at posedge+1: compare mid-cycle, then move to the next posedge+1.
  task automatic chk(input ctl_t e, input string tag);
    #2;
    checks++;
    assert (got === e) else begin
      failures++;
      $error("FAIL %s ctl got=%h exp=%h", tag, got, e);
    end
    checks++;
    assert (Instr_Count === mcount) else begin
      failures++;
      $error("FAIL %s count got=%h exp=%h", tag, Instr_Count, mcount);
    end
    @(posedge Clock);
    #1;
  endtask

  // Micro-operation expansion of one instruction from the ISA rules.
  // Returns 1 when the instruction retires.
  function automatic bit expand(input logic [15:0] ins, input bit z);
    ctl_t c;
    logic [3:0] op;
    logic [2:0] rd, rs1, rs2;
    op  = ins[15:12];
    rd  = ins[11:9];
    rs1 = ins[8:6];
    rs2 = ins[5:3];
    exp_q.delete();
    c = '0; c.mem_read = 1'b1;                                exp_q.push_back(c);
    c = '0; c.ir_write = 1'b1; c.pc_write = 1'b1;             exp_q.push_back(c);
    c = '0; c.reg_num = rs1; c.rf_read = 1'b1; c.a_write = 1'b1;
    c.illegal = !(op <= 4'd7 || op == 4'hF);
    exp_q.push_back(c);
    if (op <= 4'd3 || op == 4'd6 || op == 4'd7) begin
      c = '0; c.reg_num = rs2; c.rf_read = 1'b1; c.b_write = 1'b1;
      exp_q.push_back(c);
    end
    if (op <= 4'd4 || op == 4'd7) begin
      c = '0; c.alu_out_write = 1'b1;
      c.alu = (op == 4'd4) ? 3'b100 : (op == 4'd7) ? 3'b001 : op[2:0];
      exp_q.push_back(c);
    end
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4: begin
        c = '0; c.reg_num = rd; c.rf_write = 1'b1; exp_q.push_back(c);
      end
      4'd5: begin
        c = '0; c.addr_src = 1'b1; c.mem_read = 1'b1; exp_q.push_back(c);
        c = '0; c.reg_num = rd; c.rf_write = 1'b1; c.wb_src = 1'b1;
        exp_q.push_back(c);
      end
      4'd6: begin
        c = '0; c.addr_src = 1'b1; c.mem_write = 1'b1; exp_q.push_back(c);
      end
      4'd7: begin
        c = '0; c.reg_num = rd; c.rf_read = 1'b1;
        c.pc_write = z; c.pc_src = z;
        exp_q.push_back(c);
      end
      default: ;
    endcase
    return (op <= 4'd7);
  endfunction

  function automatic int unsigned latency(input logic [3:0] op);
    if (op <= 4'd3 || op == 4'd7) return 6;
    if (op >= 4'd4 && op <= 4'd6) return 5;
    return 3;
  endfunction

  task automatic run_instr(input logic [15:0] ins, input bit z, input string tag);
    bit r;
    Instr = ins;
    Zero  = z;
    r = expand(ins, z);
    checks++;
    assert (exp_q.size() == latency(ins[15:12])) else begin
      failures++;
      $error("FAIL %s_len got=%0d exp=%0d", tag, exp_q.size(), latency(ins[15:12]));
    end
    foreach (exp_q[i]) chk(exp_q[i], tag);
    if (r) mcount = mcount + 16'd1;
  endtask

  ctl_t zero_c, init_c, halt_c;

  initial begin
    bit r;
    zero_c = '0;
    init_c = '0; init_c.mem_reset = 1'b1;
    halt_c = '0; halt_c.halted = 1'b1;

    // Reset
    @(posedge Clock); @(posedge Clock); #1;
    chk(zero_c, "reset");
    Reset = 1'b0;
    chk(init_c, "init");
    chk(zero_c, "idle0");
    chk(zero_c, "idle1");
    Start = 1'b1;
    chk(zero_c, "idle_start");
    Start = 1'b0;

    // Directed instructions
    run_instr(16'h0628, 1'b0, "add");
    run_instr(16'h5440, 1'b0, "ld");
    run_instr(16'h7A50, 1'b1, "beq_taken");
    run_instr(16'h7A50, 1'b0, "beq_not");
    run_instr(16'h4E40, 1'b1, "not");
    run_instr(16'h60F8, 1'b0, "st");
    run_instr(16'h1FFF, 1'b0, "sub");
    run_instr(16'h2248, 1'b1, "and");
    run_instr(16'h3C90, 1'b0, "or");
    run_instr(16'h8000, 1'b0, "illegal");
    run_instr(16'hE1C0, 1'b1, "illegal_e");

    // Random instruction stream (no HALT)
    for (int i = 0; i < 60; i++) begin
      logic [15:0] ins;
      ins = {4'($urandom_range(0, 14)), 12'($urandom)};
      run_instr(ins, 1'($urandom), "rand");
    end

    // Counter wrap: preset near the top while in FETCH
    force dut.instr_count_q = 16'hFFFE;
    #1;
    release dut.instr_count_q;
    mcount = 16'hFFFE;
    run_instr(16'h0628, 1'b0, "wrap_a");
    run_instr(16'h5440, 1'b0, "wrap_b");
    run_instr(16'h60F8, 1'b0, "wrap_c");

    // Reset arriving in EXEC
    Instr = 16'h0628;
    Zero  = 1'b0;
    r = expand(16'h0628, 1'b0);
    for (int i = 0; i < 4; i++) chk(exp_q[i], "pre_exec");
    Reset = 1'b1;
    chk(zero_c, "reset_in_exec");
    mcount = '0;
    Reset = 1'b0;
    chk(init_c, "init_after_exec");
    Start = 1'b1;
    chk(zero_c, "idle_restart");
    Start = 1'b0;

    // HALT is sticky and ignores Start
    Instr = 16'hF1C0;
    r = expand(16'hF1C0, 1'b0);
    checks++;
    assert (r == 1'b0 && exp_q.size() == 3) else begin
      failures++;
      $error("FAIL halt_model got=%0d exp=3", exp_q.size());
    end
    foreach (exp_q[i]) chk(exp_q[i], "halt_seq");
    for (int i = 0; i < 20; i++) begin
      Start = (i % 3 == 0);
      chk(halt_c, "halted");
    end
    Start = 1'b0;
    Reset = 1'b1;
    chk(zero_c, "reset_in_halt");
    Reset = 1'b0;
    chk(init_c, "init_after_halt");
    chk(zero_c, "idle_after_halt");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
